// File: rtl/man_seq_checker.sv
// man_seq_checker
// Tracks a received stream of 3-bit MAN sequence codes, acquires lock after
// three consecutive in-order codes, and flags mismatches while locked. A
// single mismatch is bridged by advancing the expected position (flywheel);
// a second consecutive mismatch drops lock and restarts the hunt.
//
// Optional feature macro: MAN_ERRCNT_EN adds the err_cnt output, a
// saturating 8-bit count of err pulses.
//
// Ports
//   clk        in   rising-edge clock for all state
//   rst        in   synchronous, active-high reset
//   code_in    in   [2:0] received code {a,b,c}
//   code_valid in   code_in is sampled only when this is 1
//   index_out  out  [2:0] cycle position of the current `last` value (registered)
//   locked     out  1 while the checker is locked (registered)
//   err        out  one-cycle pulse per mismatch while locked (registered)
//   err_cnt    out  [7:0] saturating err pulse count (MAN_ERRCNT_EN only)
module man_seq_checker (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] code_in,
  input  logic       code_valid,
  output logic [2:0] index_out,
  output logic       locked,
  output logic       err
`ifdef MAN_ERRCNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Position of a code within the fixed MAN cycle.
  function automatic logic [2:0] idx_of(input logic [2:0] code);
    logic [2:0] idx;
    case (code)
      3'b000:  idx = 3'd0;
      3'b010:  idx = 3'd1;
      3'b111:  idx = 3'd2;
      3'b100:  idx = 3'd3;
      3'b101:  idx = 3'd4;
      3'b001:  idx = 3'd5;
      3'b011:  idx = 3'd6;
      3'b110:  idx = 3'd7;
      default: idx = 3'd0;
    endcase
    return idx;
  endfunction

  // Code that must follow `code` in the MAN cycle (110 wraps to 000).
  function automatic logic [2:0] succ_of(input logic [2:0] code);
    logic [2:0] nxt;
    case (code)
      3'b000:  nxt = 3'b010;
      3'b010:  nxt = 3'b111;
      3'b111:  nxt = 3'b100;
      3'b100:  nxt = 3'b101;
      3'b101:  nxt = 3'b001;
      3'b001:  nxt = 3'b011;
      3'b011:  nxt = 3'b110;
      3'b110:  nxt = 3'b000;
      default: nxt = 3'b000;
    endcase
    return nxt;
  endfunction

  state_t     state_q, state_d;
  logic [2:0] last_q, last_d;
  logic [1:0] match_cnt_q, match_cnt_d;
  logic       miss_cnt_q, miss_cnt_d;
  logic [2:0] index_q, index_d;
  logic       locked_q, locked_d;
  logic       err_q, err_d;
`ifdef MAN_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;
`endif

  // Next-state and next-output logic; everything holds on invalid cycles.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    index_d     = index_q;
    locked_d    = locked_q;
    err_d       = 1'b0;
    if (code_valid) begin
      case (state_q)
        HUNT: begin
          last_d      = code_in;
          match_cnt_d = 2'd0;
          state_d     = VERIFY;
        end
        VERIFY: begin
          last_d = code_in;
          if (code_in == succ_of(last_q)) begin
            // match_cnt already holding 2 means this is the third match.
            if (match_cnt_q == 2'd2) begin
              state_d     = LOCKED;
              match_cnt_d = 2'd0;
              miss_cnt_d  = 1'b0;
            end else begin
              match_cnt_d = match_cnt_q + 2'd1;
            end
          end else begin
            match_cnt_d = 2'd0;
          end
        end
        LOCKED: begin
          if (code_in == succ_of(last_q)) begin
            last_d     = code_in;
            miss_cnt_d = 1'b0;
          end else begin
            // Flywheel: assume the code was corrupted and keep counting.
            err_d      = 1'b1;
            last_d     = succ_of(last_q);
            miss_cnt_d = 1'b1;
            if (miss_cnt_q) begin
              state_d = HUNT;
            end else begin
              state_d = LOCKED;
            end
          end
        end
        default: begin
          state_d = HUNT;
        end
      endcase
      index_d  = idx_of(last_d);
      locked_d = (state_d == LOCKED);
    end else begin
      err_d = 1'b0;
    end
  end

`ifdef MAN_ERRCNT_EN
  // Saturating err pulse counter, updated together with the err flop.
  always_comb begin
    if (err_d && (err_cnt_q != 8'd255)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end
`endif

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HUNT;
      last_q      <= 3'b000;
      match_cnt_q <= 2'd0;
      miss_cnt_q  <= 1'b0;
      index_q     <= 3'd0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
`ifdef MAN_ERRCNT_EN
      err_cnt_q   <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      index_q     <= index_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
`ifdef MAN_ERRCNT_EN
      err_cnt_q   <= err_cnt_d;
`endif
    end
  end

  assign index_out = index_q;
  assign locked    = locked_q;
  assign err       = err_q;
`ifdef MAN_ERRCNT_EN
  assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_man_seq_checker.sv
// Self-checking bench for man_seq_checker: a position-based model of the
// MAN cycle is compared against the DUT every cycle, plus literal checks.
module tb_man_seq_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] code_in;
  logic       code_valid;
  logic [2:0] index_out;
  logic       locked;
  logic       err;
`ifdef MAN_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  always #5 clk = ~clk;

  man_seq_checker dut (
    .clk       (clk),
    .rst       (rst),
    .code_in   (code_in),
    .code_valid(code_valid),
    .index_out (index_out),
    .locked    (locked),
    .err       (err)
`ifdef MAN_ERRCNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit chk_en    = 1'b0;

  // MAN cycle listed in order; a code's position is its array index.
  int seq [8] = '{0, 2, 7, 4, 5, 1, 3, 6};

  // Model: mode 0=hunting, 1=verifying, 2=locked; p = position of last code.
  int m_mode = 0;
  int m_p    = 0;
  int m_run  = 0;
  bit m_miss = 1'b0;
  bit m_err  = 1'b0;
  int m_ecnt = 0;

  function automatic int pos_of(input logic [2:0] c);
    for (int i = 0; i < 8; i++) begin
      if (seq[i] == int'(c)) return i;
    end
    return -1;
  endfunction

  task automatic model_step(input bit r, input bit v, input logic [2:0] c);
    int q;
    m_err = 1'b0;
    if (r) begin
      m_mode = 0; m_p = 0; m_run = 0; m_miss = 1'b0; m_ecnt = 0;
    end else if (v) begin
      q = pos_of(c);
      if (m_mode == 0) begin
        m_p = q; m_run = 0; m_mode = 1;
      end else if (m_mode == 1) begin
        if (q == (m_p + 1) % 8) begin
          m_run++;
          if (m_run == 3) begin
            m_mode = 2; m_run = 0; m_miss = 1'b0;
          end
        end else begin
          m_run = 0;
        end
        m_p = q;
      end else begin
        if (q == (m_p + 1) % 8) begin
          m_p = q; m_miss = 1'b0;
        end else begin
          m_err = 1'b1;
          m_p = (m_p + 1) % 8;
          if (m_miss) m_mode = 0;
          m_miss = 1'b1;
          if (m_ecnt < 255) m_ecnt++;
        end
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("index_out", int'(index_out), m_p);
      check("locked", int'(locked), int'(m_mode == 2));
      check("err", int'(err), int'(m_err));
`ifdef MAN_ERRCNT_EN
      check("err_cnt", int'(err_cnt), m_ecnt);
`endif
    end
  end

  // Drive one cycle (called just after a falling edge), update the model at
  // the rising edge, and return on the next falling edge.
  task automatic step(input bit r, input bit v, input logic [2:0] c);
    rst = r; code_valid = v; code_in = c;
    @(posedge clk);
    model_step(r, v, c);
    chk_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic feed(input logic [2:0] c);
    step(1'b0, 1'b1, c);
  endtask

  task automatic gap();
    step(1'b0, 1'b0, 3'b000);
  endtask

  initial begin
    rst = 1'b1; code_valid = 1'b0; code_in = 3'b000;
    @(negedge clk);
    step(1'b1, 1'b0, 3'b000);
    step(1'b1, 1'b1, 3'b101);
    check("rst_index", int'(index_out), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_err", int'(err), 0);

    // Acquisition: 000,010,111,100
    feed(3'b000); feed(3'b010); feed(3'b111);
    check("acq_not_yet", int'(locked), 0);
    feed(3'b100);
    check("acq_locked", int'(locked), 1);
    check("acq_index", int'(index_out), 3);

    // Wrap-around
    feed(3'b101); feed(3'b001); feed(3'b011);
    check("wrap_idx6", int'(index_out), 6);
    feed(3'b110);
    check("wrap_idx7", int'(index_out), 7);
    feed(3'b000);
    check("wrap_idx0", int'(index_out), 0);
    check("wrap_err", int'(err), 0);

    // Single error after 101 (index 4)
    feed(3'b010); feed(3'b111); feed(3'b100); feed(3'b101);
    feed(3'b111);
    check("se_err", int'(err), 1);
    check("se_fly_idx", int'(index_out), 5);
    feed(3'b011);
    check("se_idx6", int'(index_out), 6);
    check("se_err_clr", int'(err), 0);
    check("se_locked", int'(locked), 1);

    // Valid gaps: outputs hold, err stays 0
    gap(); gap();
    check("gap_idx", int'(index_out), 6);
    check("gap_locked", int'(locked), 1);
    feed(3'b110); gap(); feed(3'b000); feed(3'b010);
    check("gap_resume_idx", int'(index_out), 1);

    // Loss of lock after 010: 000, 000
    feed(3'b000);
    check("loss_err1", int'(err), 1);
    check("loss_still_locked", int'(locked), 1);
    feed(3'b000);
    check("loss_err2", int'(err), 1);
    check("loss_unlocked", int'(locked), 0);
    check("loss_fly_idx", int'(index_out), 3);
    feed(3'b101);
    check("hunt_idx", int'(index_out), 4);
    check("hunt_no_err", int'(err), 0);

    // Verify mismatch restarts the run with no err
    feed(3'b001); feed(3'b011); feed(3'b001);
    check("vmiss_err", int'(err), 0);
    check("vmiss_idx", int'(index_out), 5);
    feed(3'b011); feed(3'b110);
    check("vmiss_not_locked", int'(locked), 0);
    feed(3'b000);
    check("relock", int'(locked), 1);
    check("relock_idx", int'(index_out), 0);

    // Reset while locked, with valid asserted
    step(1'b1, 1'b1, 3'b010);
    check("rst_lock_drop", int'(locked), 0);
    check("rst_lock_idx", int'(index_out), 0);
    check("rst_lock_err", int'(err), 0);
    gap();

`ifdef MAN_ERRCNT_EN
    // Drive 300 err pulses through repeated lock / loss cycles
    feed(3'b000); feed(3'b010); feed(3'b111); feed(3'b100);
    for (int i = 0; i < 150; i++) begin
      feed(3'(seq[m_p]));
      feed(3'(seq[m_p]));
      for (int k = 0; k < 4; k++) feed(3'(seq[k]));
    end
    check("cnt_sat", int'(err_cnt), 255);
    feed(3'(seq[m_p]));
    check("cnt_hold", int'(err_cnt), 255);
`endif

    gap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
